// File: rtl/bus_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_serial_tx_if
// Purpose  : Request/serial-bus bundle between a bus requester and the
//            bus_serial_tx serializer. The requester drives the transfer
//            request and the receiver-side ready; the serializer drives the
//            serial lanes and status.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_serial_tx_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) ();

  // Request side
  logic                  start;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] data_in;

  // Flow control from the downstream receiver
  logic                  ready;

  // Serial lanes and status
  logic                  tx_address;
  logic                  tx_addr_valid;
  logic                  tx_data;
  logic                  tx_data_valid;
  logic                  busy;
  logic                  done;

  // Requester view: issues transfers and observes the serial lanes
  modport master (
    output start,
    output write_en,
    output addr_in,
    output data_in,
    output ready,
    input  tx_address,
    input  tx_addr_valid,
    input  tx_data,
    input  tx_data_valid,
    input  busy,
    input  done
  );

  // Serializer view: accepts transfers and drives the serial lanes
  modport slave (
    input  start,
    input  write_en,
    input  addr_in,
    input  data_in,
    input  ready,
    output tx_address,
    output tx_addr_valid,
    output tx_data,
    output tx_data_valid,
    output busy,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/bus_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : bus_serial_tx
// Purpose  : Master-side serializer for the system bus. Latches an address,
//            a write byte and the write flag on a start pulse, then shifts
//            the address LSB-first on tx_address followed (writes only) by
//            the data byte LSB-first on tx_data. A low ready stalls the
//            current bit for as long as it stays low.
// Options  : define BUS_SERIAL_TX_PARITY_EN to append an even-parity cycle
//            after the address word and after the data word.
// Revision : 1.0 - initial release
// ============================================================================
module bus_serial_tx #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  bus_serial_tx_if.slave bus
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  // One shared bit index serves both words, so it is sized for the longer one.
  localparam int MAX_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int IDX_W     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_WIDTH - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);

  // State encoding
  localparam int          ST_W     = 3;
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_ADDR = 3'd1;
  localparam logic [ST_W-1:0] ST_DATA = 3'd2;
  localparam logic [ST_W-1:0] ST_DONE = 3'd3;
`ifdef BUS_SERIAL_TX_PARITY_EN
  localparam logic [ST_W-1:0] ST_ADDR_PAR = 3'd4;
  localparam logic [ST_W-1:0] ST_DATA_PAR = 3'd5;
`endif

  // --------------------------------------------------------------------------
  // Registers and next-state values
  // --------------------------------------------------------------------------
  logic [ST_W-1:0]       state_q, state_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  we_q,    we_d;

  // Both words are zero-extended to a common width so the shared index can
  // select a bit from either without a width mismatch.
  logic [MAX_WIDTH-1:0]  w_addr_ext;
  logic [MAX_WIDTH-1:0]  w_data_ext;
  logic                  w_addr_bit;
  logic                  w_data_bit;

  assign w_addr_ext = MAX_WIDTH'(addr_q);
  assign w_data_ext = MAX_WIDTH'(data_q);
  assign w_addr_bit = w_addr_ext[idx_q];
  assign w_data_bit = w_data_ext[idx_q];

`ifdef BUS_SERIAL_TX_PARITY_EN
  logic w_addr_par;
  logic w_data_par;

  assign w_addr_par = ^addr_q;
  assign w_data_par = ^data_q;
`endif

  // --------------------------------------------------------------------------
  // State register: FSM state, bit index and the latched transfer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_ZERO;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic: accept in IDLE, advance one bit per ready cycle
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;

    case (state_q)
      ST_IDLE: begin
        // start is only honoured here; later pulses are simply dropped
        if (bus.start) begin
          addr_d  = bus.addr_in;
          data_d  = bus.data_in;
          we_d    = bus.write_en;
          idx_d   = IDX_ZERO;
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (bus.ready) begin
          if (idx_q == ADDR_LAST) begin
            idx_d = IDX_ZERO;
`ifdef BUS_SERIAL_TX_PARITY_EN
            state_d = ST_ADDR_PAR;
`else
            state_d = we_q ? ST_DATA : ST_DONE;
`endif
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

`ifdef BUS_SERIAL_TX_PARITY_EN
      ST_ADDR_PAR: begin
        if (bus.ready) begin
          state_d = we_q ? ST_DATA : ST_DONE;
        end
      end
`endif

      ST_DATA: begin
        if (bus.ready) begin
          if (idx_q == DATA_LAST) begin
            idx_d = IDX_ZERO;
`ifdef BUS_SERIAL_TX_PARITY_EN
            state_d = ST_DATA_PAR;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

`ifdef BUS_SERIAL_TX_PARITY_EN
      ST_DATA_PAR: begin
        if (bus.ready) begin
          state_d = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        // One-cycle completion, never stalled
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_ZERO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: driven from registered state only, no input feedthrough
  // --------------------------------------------------------------------------
  always_comb begin
    bus.tx_address    = 1'b0;
    bus.tx_addr_valid = 1'b0;
    bus.tx_data       = 1'b0;
    bus.tx_data_valid = 1'b0;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;

    case (state_q)
      ST_ADDR: begin
        bus.tx_address    = w_addr_bit;
        bus.tx_addr_valid = 1'b1;
        bus.busy          = 1'b1;
      end

`ifdef BUS_SERIAL_TX_PARITY_EN
      ST_ADDR_PAR: begin
        bus.tx_address    = w_addr_par;
        bus.tx_addr_valid = 1'b1;
        bus.busy          = 1'b1;
      end
`endif

      ST_DATA: begin
        bus.tx_data       = w_data_bit;
        bus.tx_data_valid = 1'b1;
        bus.busy          = 1'b1;
      end

`ifdef BUS_SERIAL_TX_PARITY_EN
      ST_DATA_PAR: begin
        bus.tx_data       = w_data_par;
        bus.tx_data_valid = 1'b1;
        bus.busy          = 1'b1;
      end
`endif

      ST_DONE: begin
        bus.done = 1'b1;
        bus.busy = 1'b1;
      end

      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_serial_tx
// Purpose  : Self-checking bench for bus_serial_tx. Each transfer is turned
//            into the ordered list of serial symbols it must produce; the
//            bench walks that list cycle by cycle, advancing on ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_serial_tx;

  localparam int AW = 12;
  localparam int DW = 8;
`ifdef BUS_SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_serial_tx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bus_serial_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // One expected output symbol: {tx_address, tx_addr_valid, tx_data,
  // tx_data_valid, busy, done} and whether ready gates leaving it.
  typedef struct {
    logic [5:0] v;
    bit         stallable;
  } sym_t;

  sym_t exp_q[$];

  function automatic logic [5:0] observe();
    return {bus.tx_address, bus.tx_addr_valid, bus.tx_data,
            bus.tx_data_valid, bus.busy, bus.done};
  endfunction

  // Reference: the symbol stream a transfer must produce
  task automatic build_expected(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic we);
    sym_t s;
    exp_q.delete();
    for (int k = 0; k < AW; k++) begin
      s.v = {a[k], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; s.stallable = 1'b1;
      exp_q.push_back(s);
    end
    if (PAR == 1) begin
      s.v = {^a, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; s.stallable = 1'b1;
      exp_q.push_back(s);
    end
    if (we) begin
      for (int k = 0; k < DW; k++) begin
        s.v = {1'b0, 1'b0, d[k], 1'b1, 1'b1, 1'b0}; s.stallable = 1'b1;
        exp_q.push_back(s);
      end
      if (PAR == 1) begin
        s.v = {1'b0, 1'b0, ^d, 1'b1, 1'b1, 1'b0}; s.stallable = 1'b1;
        exp_q.push_back(s);
      end
    end
    s.v = 6'b000011; s.stallable = 1'b0;
    exp_q.push_back(s);
  endtask

  // Runs one transfer from a negedge with the DUT idle, checking every cycle.
  // mode: 0 ready high, 1 random ready, 2 three-cycle stall on address bit 4.
  // poke: extra start pulse with a different address during ADDR.
  // hold: start stays high throughout (next transfer follows immediately).
  task automatic run_transfer(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic we, input int mode,
                              input bit poke, input bit hold);
    int pos, cyc, stalls, done_cyc, lat;
    logic [5:0] obs;
    build_expected(a, d, we);
    bus.start    = 1'b1;
    bus.addr_in  = a;
    bus.data_in  = d;
    bus.write_en = we;
    bus.ready    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start    = hold;
    bus.addr_in  = AW'($urandom);
    bus.data_in  = DW'($urandom);
    bus.write_en = 1'($urandom);
    pos = 0; cyc = 0; stalls = 0; done_cyc = -1;
    while (pos < exp_q.size() && cyc < 400) begin
      obs = observe();
      checks++;
      if (obs !== exp_q[pos].v) begin
        errors++;
        $display("FAIL xfer_out a=%h d=%h we=%0d cyc=%0d sym=%0d: got %b, want %b",
                 a, d, we, cyc, pos, obs, exp_q[pos].v);
      end
      if (exp_q[pos].v[0] && done_cyc < 0) done_cyc = cyc;
      case (mode)
        1:       bus.ready = ($urandom_range(3) != 0);
        2:       bus.ready = !(pos == 4 && stalls < 3);
        default: bus.ready = 1'b1;
      endcase
      if (exp_q[pos].stallable && !bus.ready) stalls++;
      if (poke) begin
        bus.start   = (cyc == 3);
        bus.addr_in = a ^ {AW{1'b1}};
        bus.data_in = ~d;
      end else begin
        bus.start = hold;
      end
      @(posedge clk);
      if (!exp_q[pos].stallable || bus.ready) pos++;
      @(negedge clk);
      cyc++;
    end
    bus.ready = 1'b1;
    checks++;
    if (pos != exp_q.size()) begin
      errors++;
      $display("FAIL xfer_timeout a=%h: reached symbol %0d, need %0d", a, pos, exp_q.size());
    end
    lat = AW + PAR + (we ? (DW + PAR) : 0) + stalls;
    checks++;
    if (done_cyc != lat) begin
      errors++;
      $display("FAIL done_latency a=%h we=%0d: got N+%0d, want N+%0d", a, we, done_cyc, lat);
    end
    obs = observe();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL idle_after a=%h: got %b, want 000000", a, obs);
    end
  endtask

  task automatic test_reset();
    logic [5:0]    obs;
    logic [AW-1:0] a;
    reset = 1'b1;
    bus.start = 1'b0; bus.write_en = 1'b0; bus.addr_in = '0; bus.data_in = '0;
    bus.ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs = observe();
      checks++;
      if (obs !== 6'b000000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %b, want 000000", i, obs);
      end
      @(negedge clk);
    end
    // Abort a transfer while bit 5 of the address is on the wire
    a = 12'hFE0;
    bus.start = 1'b1; bus.addr_in = a; bus.data_in = 8'hFF; bus.write_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    obs = observe();
    checks++;
    if (obs !== {a[5], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_addr_bit5: got %b, want %b", obs, {a[5], 5'b10010});
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    obs = observe();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL reset_mid_xfer: got %b, want 000000", obs);
    end
    @(posedge clk);
    @(negedge clk);
    obs = observe();
    checks++;
    if (obs !== 6'b000000) begin
      errors++;
      $display("FAIL reset_stays_idle: got %b, want 000000", obs);
    end
    // A fresh transfer must start clean after the aborted one
    run_transfer(12'h5A3, 8'hC6, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_write_vector();
    run_transfer(12'hA5C, 8'h3B, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_vector();
    run_transfer(12'h001, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_transfer(12'h3D9, 8'h94, 1'b1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_transfer(12'h813, 8'h7E, 1'b1, 0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_transfer(12'hC0F, 8'h55, 1'b0, 0, 1'b0, 1'b1);
    run_transfer(12'h2B4, 8'hA9, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_parity_vector();
    run_transfer(12'h007, 8'h01, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_transfer(AW'($urandom), DW'($urandom), 1'($urandom), 1, 1'b0, 1'b0);
      repeat ($urandom_range(2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_write_vector();
    test_read_vector();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_parity_vector();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/bus_serial_tx.md
Name: bus_serial_tx

Overview:
- Master-side serializer for the system bus.
- Latches a 12-bit address and an 8-bit write byte on a start pulse.
- Shifts the address LSB-first on the serial address line, then the data byte LSB-first on the serial data line.
- Sits directly upstream of the slave-side serial address/data receiver, which rebuilds address[11:0] and the data byte one bit per clock.

Parameters:
- ADDR_WIDTH, 12, number of address bits serialized.
- DATA_WIDTH, 8, number of data bits serialized.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- write_en  input  1  1 = address + data transfer; 0 = address-only (read request).
- addr_in  input  ADDR_WIDTH  address to send; latched when start is accepted.
- data_in  input  DATA_WIDTH  byte to send; latched when start is accepted.
- ready  input  1  receiver ready; low stalls the current bit.
- tx_address  output  1  serial address bit.
- tx_addr_valid  output  1  tx_address carries a valid bit this cycle.
- tx_data  output  1  serial data bit.
- tx_data_valid  output  1  tx_data carries a valid bit this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle completion pulse.

Behaviour:
- One clock domain. Reset is synchronous and active-high: reset sampled high on a clk rising edge forces state IDLE, bit index 0, and latched address/data/write_en registers to 0. All outputs are 0 after reset.
- Outputs are decoded from registered state only. There is no combinational path from any input to any output.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - All outputs 0.
  - start=1 latches addr_in, data_in and write_en, clears the index, and moves to ADDR.
- ADDR:
  - tx_address = addr_reg[idx]; tx_addr_valid = 1.
  - On an edge with ready=1: idx increments.
  - At idx = ADDR_WIDTH-1 with ready=1: idx clears; next state is DATA if write_en_reg=1, else DONE.
- DATA:
  - tx_data = data_reg[idx]; tx_data_valid = 1.
  - On an edge with ready=1: idx increments.
  - At idx = DATA_WIDTH-1 with ready=1: go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
- ready=0 in ADDR or DATA: state, idx and the output bit all hold. A stall has no length limit.
- Latency with ready held high, start sampled at edge N:
  - Address bit k is valid from edge N+k.
  - Write: data bit k valid from edge N+12+k; done high from edge N+20.
  - Read: done high from edge N+12.
- start is ignored in ADDR, DATA and DONE, with no queueing. addr_in and data_in may change freely after acceptance.
- Back-to-back transfers: earliest next acceptance is the IDLE cycle after DONE.
- Reset mid-transfer: the next cycle is IDLE with all outputs 0, and the partial word is discarded.
- Index register is clog2(max(ADDR_WIDTH, DATA_WIDTH)) wide. Its compare is exact and it never wraps past the width.

Optional Feature:
- Macro: BUS_SERIAL_TX_PARITY_EN.
- Defined:
  - After the last address bit, one extra ADDR_PAR cycle drives tx_address = even parity (XOR) of addr_reg, with tx_addr_valid=1.
  - After the last data bit, one extra DATA_PAR cycle drives tx_data = XOR of data_reg, with tx_data_valid=1.
  - Both parity cycles obey ready stalls.
  - Write latency becomes done at N+22; read latency becomes done at N+13.
- Undefined: no parity states, and timing is exactly as above.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0. Assert reset mid-ADDR at bit 5 -> next cycle IDLE, outputs 0, busy 0.
- start with write_en=1, addr_in=12'hA5C, data_in=8'h3B, ready=1 -> tx_address serial 0,0,1,1,1,0,1,0,0,1,0,1 on edges N..N+11; tx_data 1,1,0,1,1,1,0,0 on edges N+12..N+19; done pulse at N+20 only.
- start with write_en=0, addr_in=12'h001 -> one 1 then eleven 0s on tx_address; tx_data_valid never high; done at N+12.
- Write transfer with ready held low for 3 cycles at address bit 4 -> bit 4 held 4 cycles total; done at N+23.
- start pulsed again during ADDR with a different addr_in -> ignored, original address continues. start held high through DONE -> second transfer accepted in the following IDLE cycle.
- With BUS_SERIAL_TX_PARITY_EN, addr 12'h007, data 8'h01 -> address parity bit 1 at N+12; data 1,0,0,0,0,0,0,0 at N+13..N+20; data parity bit 1 at N+21; done at N+22.
